// File: rtl/vga_frame_scheduler_if.sv
// rtl/vga_frame_scheduler_if.sv - SIMD write channel and framebuffer RAM port bundle
interface vga_frame_scheduler_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Scheduler side: accepts writes, drives the RAM port.
    modport slave (
        input  wr_valid, wr_addr, wr_data, ram_rdata,
        output wr_ready, ram_en, ram_we, ram_addr, ram_wdata
    );

    // SIMD core / RAM side.
    modport master (
        output wr_valid, wr_addr, wr_data, ram_rdata,
        input  wr_ready, ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/vga_frame_scheduler.sv
// rtl/vga_frame_scheduler.sv - VGA timing master sharing one framebuffer port between scan-out and buffered writes
module vga_frame_scheduler #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vga_frame_scheduler_if.slave  bus,
    output logic [DATA_W-1:0]     pixel,
    output logic                  vga_hs,
    output logic                  vga_vs,
    output logic                  vga_de,
    output logic                  frame_start,
    output logic                  vblank
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int CW      = PW + 1;

    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic [ADDR_W-1:0] fetch_q, fetch_d;
    logic              h_last, v_last, de0, hs0, vs0;

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              full, empty, push, pop;

    logic              de1_q, hs1_q, vs1_q;
    logic              de2_q, hs2_q, vs2_q;
    logic [DATA_W-1:0] pixel_q;

    assign h_last = (h_q == HW'(H_TOTAL - 1));
    assign v_last = (v_q == VW'(V_TOTAL - 1));
    assign de0    = (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
    assign hs0    = !((h_q >= HW'(H_ACTIVE + H_FP)) && (h_q < HW'(H_ACTIVE + H_FP + H_SYNC)));
    assign vs0    = !((v_q >= VW'(V_ACTIVE + V_FP)) && (v_q < VW'(V_ACTIVE + V_FP + V_SYNC)));

    // fetch_addr is zeroed on the frame's last cycle so it reads 0 at (0,0).
    always_comb begin
        h_d     = h_last ? '0 : h_q + 1'b1;
        v_d     = v_q;
        fetch_d = fetch_q;
        if (h_last) v_d = v_last ? '0 : v_q + 1'b1;
        if (h_last && v_last) fetch_d = '0;
        else if (de0)         fetch_d = fetch_q + 1'b1;
    end

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.wr_valid && !full;
    assign pop   = !de0 && !empty;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wptr_q] <= bus.wr_addr;
            fifo_data_q[wptr_q] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q     <= '0;
            v_q     <= '0;
            fetch_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            de1_q   <= 1'b0;
            hs1_q   <= 1'b1;
            vs1_q   <= 1'b1;
            de2_q   <= 1'b0;
            hs2_q   <= 1'b1;
            vs2_q   <= 1'b1;
            pixel_q <= '0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            fetch_q <= fetch_d;
            count_q <= count_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            de1_q   <= de0;
            hs1_q   <= hs0;
            vs1_q   <= vs0;
            de2_q   <= de1_q;
            hs2_q   <= hs1_q;
            vs2_q   <= vs1_q;
            pixel_q <= de1_q ? bus.ram_rdata : '0;
        end
    end

    // Display read always wins the port; queued writes only use non-display cycles.
    assign bus.ram_en    = rst_n && (de0 || pop);
    assign bus.ram_we    = rst_n && pop;
    assign bus.ram_addr  = de0 ? fetch_q : fifo_addr_q[rptr_q];
    assign bus.ram_wdata = fifo_data_q[rptr_q];
    assign bus.wr_ready  = !full;

    assign frame_start = rst_n && (h_q == '0) && (v_q == '0);
    assign vblank      = (v_q >= VW'(V_ACTIVE));
    assign pixel       = pixel_q;
    assign vga_de      = de2_q;
    assign vga_hs      = hs2_q;
    assign vga_vs      = vs2_q;
endmodule

// File: tb/tb_vga_frame_scheduler.sv
// tb/tb_vga_frame_scheduler.sv - randomized bench with queue-based reference model on a shrunken frame
module tb_vga_frame_scheduler;
    localparam int HA = 40, HF = 4, HS = 8, HB = 6, HT = HA + HF + HS + HB;
    localparam int VA = 20, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
    localparam int AW = 19, DW = 8, DEPTH = 4;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } w_t;
    typedef struct { bit de; bit hs; bit vs; logic [DW-1:0] pix; } s_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] pixel;
    logic          vga_hs, vga_vs, vga_de, frame_start, vblank;

    int total = 0;
    int bad   = 0;
    int n;
    w_t q[$];
    s_t hist[$];
    bit          exp_vld [1024];
    bit [DW-1:0] exp_val [1024];
    bit          env_vld [1024];
    bit [DW-1:0] env_val [1024];

    vga_frame_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    vga_frame_scheduler #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .pixel(pixel), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
        .frame_start(frame_start), .vblank(vblank)
    );

    always #20 clk = ~clk;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return DW'(a * 7 + 3);
    endfunction

    // Framebuffer RAM with 1-cycle read latency.
    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) begin
                env_vld[bus.ram_addr[9:0]] <= 1'b1;
                env_val[bus.ram_addr[9:0]] <= bus.ram_wdata;
            end else begin
                bus.ram_rdata <= env_vld[bus.ram_addr[9:0]] ? env_val[bus.ram_addr[9:0]] : pat(bus.ram_addr);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_rd(input int a);
        return exp_vld[a % 1024] ? exp_val[a % 1024] : pat(AW'(a));
    endfunction

    task automatic set_wr(input bit valid, input int a, input int d);
        bus.wr_valid = valid;
        bus.wr_addr  = AW'(a);
        bus.wr_data  = DW'(d);
    endtask

    // One pixel clock: check at negedge against the model, then advance the model.
    task automatic tick();
        int h, v, fa;
        bit de0, hs0, vs0, rdy, do_pop;
        s_t o, s;
        w_t e;
        h   = n % HT;
        v   = (n / HT) % VT;
        fa  = v * HA + h;
        de0 = (h < HA) && (v < VA);
        hs0 = !((h >= HA + HF) && (h < HA + HF + HS));
        vs0 = !((v >= VA + VF) && (v < VA + VF + VS));
        rdy = q.size() < DEPTH;
        do_pop = !de0 && (q.size() > 0);
        @(negedge clk);
        chk("frame_start", frame_start, (h == 0 && v == 0));
        chk("vblank", vblank, (v >= VA));
        chk("wr_ready", bus.wr_ready, rdy);
        chk("ram_en", bus.ram_en, de0 || do_pop);
        chk("ram_we", bus.ram_we, do_pop);
        if (de0) chk("rd_addr", bus.ram_addr, fa);
        if (do_pop) begin
            chk("wr_addr", bus.ram_addr, q[0].a);
            chk("wr_data", bus.ram_wdata, q[0].d);
        end
        if (hist.size() == 2) o = hist[0];
        else o = '{de: 1'b0, hs: 1'b1, vs: 1'b1, pix: '0};
        chk("pixel", pixel, o.pix);
        chk("vga_de", vga_de, o.de);
        chk("vga_hs", vga_hs, o.hs);
        chk("vga_vs", vga_vs, o.vs);
        s = '{de: de0, hs: hs0, vs: vs0, pix: de0 ? model_rd(fa) : '0};
        hist.push_back(s);
        if (hist.size() > 2) void'(hist.pop_front());
        @(posedge clk);
        if (do_pop) begin
            e = q.pop_front();
            exp_vld[e.a[9:0]] = 1'b1;
            exp_val[e.a[9:0]] = e.d;
        end
        if (bus.wr_valid && rdy) q.push_back('{a: bus.wr_addr, d: bus.wr_data});
        n++;
        #1;
    endtask

    task automatic reset_chk();
        chk("rst_pixel", pixel, 0);
        chk("rst_hs", vga_hs, 1);
        chk("rst_vs", vga_vs, 1);
        chk("rst_de", vga_de, 0);
        chk("rst_ram_en", bus.ram_en, 0);
        chk("rst_ram_we", bus.ram_we, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_wr_ready", bus.wr_ready, 1);
        chk("rst_vblank", vblank, 0);
    endtask

    task automatic goto_hv(input int h, input int v);
        for (int k = 0; k < HT * VT + 1; k++) begin
            if ((n % HT) == h && ((n / HT) % VT) == v) break;
            tick();
        end
    endtask

    task automatic rand_run(input int cycles, input int one_in);
        for (int k = 0; k < cycles; k++) begin
            set_wr($urandom_range(one_in - 1) == 0, $urandom_range(HA * VA - 1), $urandom);
            tick();
        end
        set_wr(0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        set_wr(0, 0, 0);
        n = 0;
        repeat (3) @(posedge clk);
        #1 reset_chk();
        @(negedge clk) reset_chk();
        @(posedge clk) #1;
        rst_n = 1'b1;

        // Single write inside active video waits for the line's blanking.
        goto_hv(10, 5);
        set_wr(1, 100, 8'hA5);
        tick();
        set_wr(0, 0, 0);
        goto_hv(HA + 3, 5);

        // Five back-to-back writes during active video: only four fit.
        goto_hv(5, 7);
        for (int k = 0; k < 5; k++) begin
            set_wr(1, 200 + k, 8'h30 + k);
            tick();
        end
        set_wr(0, 0, 0);
        goto_hv(0, 8);

        rand_run(2 * HT * VT, 3);

        // Sustained write stream through vertical blanking.
        goto_hv(0, VA);
        for (int k = 0; k < 3 * HT; k++) begin
            set_wr(1, $urandom_range(HA * VA - 1), $urandom);
            tick();
        end
        set_wr(0, 0, 0);

        // Mid-frame reset with three writes still queued.
        goto_hv(30, 10);
        for (int k = 0; k < 3; k++) begin
            set_wr(1, 300 + k, 8'hC0 + k);
            tick();
        end
        set_wr(0, 0, 0);
        rst_n = 1'b0;
        #1 reset_chk();
        @(negedge clk) reset_chk();
        @(posedge clk) #1;
        n = 0;
        q.delete();
        hist.delete();
        rst_n = 1'b1;

        rand_run(HT * VT + 2 * HT, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vga_frame_scheduler.md
# vga_frame_scheduler

Sequences the 640x480 VGA scan and shares the single-port framebuffer RAM between display scan-out and the SIMD core's pixel writes. Each cycle it decides who owns the RAM port. Scan-out reads own the port during active video. SIMD writes are buffered in a small FIFO and drained into the RAM during horizontal and vertical blanking. It replaces the free-running h/v sync generators as the single timing master for the VGA path.

## Interface
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal porch/sync widths; H_TOTAL = 800
- V_ACTIVE, 480: visible lines
- V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical porch/sync widths; V_TOTAL = 525
- ADDR_W, 19: framebuffer address width
- DATA_W, 8: pixel width
- FIFO_DEPTH, 4: write FIFO entries (power of 2)

Ports:
- clk  in  1  pixel clock (25 MHz); single clock domain
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  SIMD write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write pixel
- wr_ready  out  1  FIFO can accept; `= !full`
- ram_en  out  1  RAM port enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, 1-cycle latency
- pixel  out  DATA_W  output pixel, 0 when blanked
- vga_hs, vga_vs  out  1  syncs, active low
- vga_de  out  1  display enable, aligned with pixel
- frame_start  out  1  1-cycle pulse at h=0, v=0 (stage 0)
- vblank  out  1  high while v_count >= V_ACTIVE (stage 0)

## Operation
- Stage 0 counters: h_count 0..H_TOTAL-1, wraps to 0. v_count increments on each h wrap and wraps at V_TOTAL-1 -> 0.
- de0 = (h_count < H_ACTIVE) && (v_count < V_ACTIVE).
- hs0 is low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751.
- vs0 is low for v in [V_ACTIVE+V_FP, +V_SYNC), i.e. 490..491.
- fetch_addr register: cleared when h=0 and v=0; increments after every de0 cycle. It therefore equals v*H_ACTIVE + h during active video. Maximum value 307199, no wrap.
- Port arbitration, evaluated each cycle:
  - If de0: display read. ram_en=1, ram_we=0, ram_addr=fetch_addr.
  - Else if FIFO not empty: pop the head. ram_en=1, ram_we=1, ram_addr/ram_wdata from the head entry.
  - Else: ram_en=0, ram_we=0.
  - The display always wins. Writes never stall scan-out.
- Write FIFO:
  - Push on wr_valid && wr_ready.
  - Pop on a granted write.
  - Push and pop in the same cycle leave the count unchanged.
  - No push when full, even if a pop occurs that cycle (wr_ready depends on the registered full flag only).
  - Writes commit in acceptance order.
- Scan-out pipeline:
  - Stage 1 registers de/hs/vs.
  - Stage 2 registers pixel = de1 ? ram_rdata : 0, plus vga_de/vga_hs/vga_vs.
- Reset (async, any time, including mid-frame or mid-drain):
  - Counters and fetch_addr are 0.
  - FIFO is emptied; pending entries are discarded.
  - pixel=0, vga_hs=1, vga_vs=1, vga_de=0, ram_en=0, ram_we=0.
  - frame_start=0 while rst_n is low. It pulses in the first cycle after release because the counters are at (0,0).
  - wr_ready=1, vblank=0.

## Timing
- Pixel latency: counter at (h,v) in cycle t -> ram_addr in t -> ram_rdata in t+1 -> pixel/vga_de/vga_hs/vga_vs in t+2.
- frame_start and vblank are stage-0 signals and lead vga_de by 2 cycles.
- Write drain opportunities:
  - 160 cycles per line during active lines.
  - Every cycle during the 45 blanking lines.
- Write latency: from acceptance to RAM write is at least 1 cycle, or the end of the current active run if accepted during active video.
- wr_ready deasserts the cycle after the FIFO reaches FIFO_DEPTH entries. It reasserts the cycle after the first pop.

## Test plan
- Reset release: after 1 cycle, frame_start=1 and ram_addr=0 with ram_en=1. vga_de=1 at cycle 2. vga_hs falls exactly at h=656+2 cycles and stays low for 96 cycles.
- Full frame: count 420000 clocks between frame_start pulses. vga_vs is low for 1600 cycles. vga_de is high for 307200 cycles. The last read address is 307199.
- Write during active video: push (addr 100, data 0xA5) at h=10, v=5. No ram_we until h=640, where ram_we=1, addr=100, data=0xA5.
- FIFO full: 5 back-to-back writes in active video. 4 are accepted and wr_ready=0. At h=640 the 4 writes drain in order over 4 cycles. wr_ready=1 again after the first pop.
- Simultaneous push/pop in blanking: a sustained wr_valid stream keeps count ≤1. One write per cycle reaches the RAM in order.
- Mid-frame reset: assert rst_n=0 at h=300, v=200 with 3 FIFO entries. Outputs immediately reach their reset values. No queued write appears after release.
